// File: rtl/nrzi_stuff_encode.sv
// Bit-stuffing and NRZI encoder that feeds the DP/DM line encoder with one gap-free burst per packet.
// Optional macro NRZI_STUFF_STATS_EN builds the saturating stuff_count statistic (tied to 0 otherwise).
module nrzi_stuff_encode #(
    parameter int unsigned STUFF_LEN  = 6,
    parameter int unsigned START_ONES = 1,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_bit,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        enc_done,
    output logic        nrzi_out_bit,
    output logic        nrzi_sending,
    output logic        pkt_done,
    output logic        underrun,
    output logic [15:0] stuff_count
);

    localparam int unsigned CW_RAW = $clog2(STUFF_LEN + 1);
    localparam int unsigned CW     = (CW_RAW > 3) ? CW_RAW : 3;
    localparam logic [CW-1:0] RUN_LEN = CW'(STUFF_LEN);
    localparam logic [CW-1:0] START_C = CW'(START_ONES);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        STUFF,
        END,
        WAIT_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] ones_inc;
    logic [CW-1:0] bit_ones;
    logic          bit_level;
    logic          run_done;
    logic          last_seen;

    // nrzi_out_bit doubles as the NRZI line-level register
    always_comb begin
        ones_inc  = ones_cnt + 1'b1;
        run_done  = in_bit && (ones_inc == RUN_LEN);
        bit_level = in_bit ? nrzi_out_bit : ~nrzi_out_bit;
        bit_ones  = in_bit ? ones_inc : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            nrzi_out_bit <= INIT_LEVEL;
            nrzi_sending <= 1'b0;
            pkt_done     <= 1'b0;
            underrun     <= 1'b0;
            ones_cnt     <= START_C;
            last_seen    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            underrun <= 1'b0;
            case (state)
                IDLE, SEND: begin
                    if (in_valid) begin
                        nrzi_out_bit <= bit_level;
                        ones_cnt     <= bit_ones;
                        nrzi_sending <= 1'b1;
                        last_seen    <= in_last;
                        // a lone last bit passes through END so pkt_done still marks the packet end
                        if (run_done) begin
                            state    <= STUFF;
                            in_ready <= 1'b0;
                        end else if (in_last) begin
                            state    <= END;
                            in_ready <= 1'b0;
                        end else begin
                            state <= SEND;
                        end
                    end else if (state == SEND) begin
                        underrun     <= 1'b1;
                        nrzi_sending <= 1'b0;
                        nrzi_out_bit <= INIT_LEVEL;
                        ones_cnt     <= START_C;
                        state        <= IDLE;
                    end
                end
                STUFF: begin
                    nrzi_out_bit <= ~nrzi_out_bit;
                    ones_cnt     <= '0;
                    if (last_seen) begin
                        state <= END;
                    end else begin
                        state    <= SEND;
                        in_ready <= 1'b1;
                    end
                end
                END: begin
                    nrzi_sending <= 1'b0;
                    pkt_done     <= 1'b1;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (enc_done) begin
                        state        <= IDLE;
                        in_ready     <= 1'b1;
                        nrzi_out_bit <= INIT_LEVEL;
                        ones_cnt     <= START_C;
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_ready     <= 1'b1;
                    nrzi_sending <= 1'b0;
                end
            endcase
        end
    end

`ifdef NRZI_STUFF_STATS_EN
    logic [15:0] stuff_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stuff_cnt_q <= '0;
        end else if (state == STUFF && stuff_cnt_q != '1) begin
            stuff_cnt_q <= stuff_cnt_q + 16'd1;
        end
    end

    assign stuff_count = stuff_cnt_q;
`else
    assign stuff_count = '0;
`endif

endmodule
